// File: rtl/register_file_pkg.sv
// Shared processor package: datapath widths, register-index type and index helper.
package register_file_pkg;
  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  // True for indices that name a real, writable register (R0 and out-of-range excluded).
  function automatic logic idx_ok(input int idx, input int nregs);
    return (idx > 0) && (idx < nregs);
  endfunction
endpackage

// File: rtl/register_file_if.sv
// Register-file port bundle: one write port, two read ports, debug write counter.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [15:0]       wr_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, wr_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, wr_count
  );
endinterface

// File: rtl/register_file_read_port.sv
// One asynchronous read port: index decode, R0/out-of-range forcing, optional write bypass.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int NREGS  = register_file_pkg::NREGS,
  parameter int ADDR_W = register_file_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic                         wr_commit,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            rd_data
);
  // wr_commit already excludes R0, out-of-range and reset, so a hit is always a real write.
  always_comb begin
    rd_data = '0;
    if (idx_ok(int'(rd_addr), NREGS)) begin
      if ((BYPASS != 0) && wr_commit && (wr_addr == rd_addr))
        rd_data = wr_data;
      else
        rd_data = regs[rd_addr];
    end
  end
endmodule

// File: rtl/register_file.sv
// Flop-array register file with R0 hardwired to zero, two async read ports and a write counter.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int NREGS  = register_file_pkg::NREGS,
  parameter int BYPASS = 1,
  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave rf
);
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [15:0]                  count;
  logic                         commit;

  // Gated by rst so a write held during reset neither lands nor forwards.
  assign commit = rf.wr_en && !rst && idx_ok(int'(rf.wr_addr), NREGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs  <= '0;
      count <= '0;
    end else if (commit) begin
      for (int i = 1; i < NREGS; i++)
        if (rf.wr_addr == ADDR_W'(i)) regs[i] <= rf.wr_data;
      count <= count + 16'd1;
    end
  end

  assign rf.wr_count = count;

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;

  assign rd_addr = {rf.rd_addr2, rf.rd_addr1};

  for (genvar g = 0; g < 2; g++) begin : g_port
    regfile_read_port #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_port (
      .regs      (regs),
      .rd_addr   (rd_addr[g]),
      .wr_commit (commit),
      .wr_addr   (rf.wr_addr),
      .wr_data   (rf.wr_data),
      .rd_data   (rd_data[g])
    );
  end

  assign rf.rd_data1 = rd_data[0];
  assign rf.rd_data2 = rd_data[1];
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 16, shall set the register and read/write data width in bits.
REQ-002 Parameter NREGS, default 8, shall set the number of architectural registers; ADDR_W = clog2(NREGS) = 3 at default.
REQ-003 Parameter BYPASS, default 1, shall enable write-to-read forwarding when 1 and disable it when 0.
REQ-004 clk  input  1  shall be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  shall be the asynchronous, active-high reset.
REQ-006 wr_en  input  1  shall be the write enable for the write port.
REQ-007 wr_addr  input  ADDR_W  shall be the destination register index.
REQ-008 wr_data  input  DATA_W  shall be the write data, typically the ALU answer or memory data.
REQ-009 rd_addr1  input  ADDR_W  shall be the read-port-1 index (rs).
REQ-010 rd_addr2  input  ADDR_W  shall be the read-port-2 index (rt).
REQ-011 rd_data1  output  DATA_W  shall be the read-port-1 data and shall drive the ALU input1.
REQ-012 rd_data2  output  DATA_W  shall be the read-port-2 data and shall drive the ALU input2 via the operand mux.
REQ-013 wr_count  output  16  shall count committed writes, for debug and the bench.

Function
REQ-014 Storage: the block shall hold NREGS registers of DATA_W bits; R0 shall be hardwired to zero.
REQ-015 Write: on a rising clk edge with wr_en=1 and wr_addr!=0, reg[wr_addr] shall take wr_data; the new value shall be visible on a non-bypassed read in the next cycle.
REQ-016 A write to R0 shall be discarded and shall not increment wr_count.
REQ-017 With wr_en=0, no register and no counter shall change.
REQ-018 Read: each read port shall be combinational from its rd_addr with zero-cycle latency, so that single-cycle issue is preserved.
REQ-019 Reading R0 shall return 0 on either port under all conditions, including a simultaneous write to R0.
REQ-020 Bypass: if BYPASS=1, wr_en=1, wr_addr!=0 and rd_addrN==wr_addr, rd_dataN shall equal wr_data in the same cycle.
REQ-021 With BYPASS=0, the same case shall return the old register value until the edge.
REQ-022 Both read ports may address the same register simultaneously; both shall return identical data.
REQ-023 wr_count shall increment by 1 per committed write and shall wrap from 0xFFFF to 0x0000.
REQ-024 Out-of-range indices (NREGS not a power of 2, addr>=NREGS) shall read 0 and shall ignore writes.

Reset
REQ-025 Assertion of rst shall, asynchronously and without a clock, clear all registers and wr_count to 0; rd_data1 and rd_data2 shall then read 0.
REQ-026 A write coincident with rst asserted shall be discarded.
REQ-027 Writes shall commit starting from the first rising edge after rst deasserts.
REQ-028 Reset asserted mid-sequence shall discard all prior contents with no partial retention.

Structure
REQ-029 DATA_W, NREGS, ADDR_W and the reg-index typedef shall live in the shared processor package, which the ALU and control unit also use.
REQ-030 One sub-module, regfile_read_port (index decode, R0 forcing and bypass mux), shall be instantiated twice.
REQ-031 There shall be no other hierarchy; storage shall be a flop array, not an inferred RAM, because reads are asynchronous.

Verification
REQ-032 Reset: pulse rst, then read all 8 registers on both ports -> every read is 0x0000 and wr_count is 0.
REQ-033 Write and read: write R1=9 and R2=4, then read rd_addr1=1 and rd_addr2=2 -> 9 and 4; ALU ADD gives 13, SUB gives 5, AND gives 0, OR gives 13; wr_count is 2.
REQ-034 R0 protection: write R0=0xBEEF, then read R0 on both ports -> 0x0000 and wr_count is unchanged.
REQ-035 Bypass: with R3=0x0011, hold wr_en=1, wr_addr=3, wr_data=0x00AA and rd_addr1=3 in the same cycle -> rd_data1 is 0x00AA when BYPASS=1 and 0x0011 when BYPASS=0.
REQ-036 Reset mid-operation: write R5=0x1234, assert rst between clock edges -> R5 reads 0 immediately, and a write held during rst is not committed.
REQ-037 Counter wrap: preload via 65536 writes to R7 -> wr_count returns to 0x0000 and R7 holds the last written value.
